// File: rtl/progmem_prefetch_if.sv
// CPU-side and ROM-side signal bundle for progmem_prefetch.
interface progmem_prefetch_if;
  logic        cpu_valid;
  logic        cpu_instr;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        bus_err;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_valid, cpu_instr, cpu_addr, mem_ready, mem_rdata,
    output cpu_ready, cpu_rdata, bus_err, mem_valid, mem_addr
  );

  modport master (
    output cpu_valid, cpu_instr, cpu_addr, mem_ready, mem_rdata,
    input  cpu_ready, cpu_rdata, bus_err, mem_valid, mem_addr
  );
endinterface

// File: rtl/progmem_prefetch.sv
// Program-ROM front end: single-entry next-word prefetch buffer with a
// bounded ROM access time so unmapped fetches return an error word.
module progmem_prefetch #(
  parameter int unsigned TIMEOUT     = 16,
  parameter bit          PREFETCH_EN = 1'b1,
  parameter logic [31:0] ERR_WORD    = 32'h00100073
) (
  input  logic               clk,
  input  logic               rstn,
  progmem_prefetch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DEMAND, RESP, PREFETCH} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [29:0] req_word;
  logic        req_instr;
  logic        req_err;
  logic        buf_valid;
  logic [29:0] buf_tag;
  logic [31:0] buf_data;
  logic [7:0]  cnt;
  logic        cpu_ready_q;
  logic [31:0] cpu_rdata_q;
  logic        bus_err_q;
  logic [31:0] mem_addr_q;

  logic busy, hit, mem_ok, mem_to;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  assign busy          = (state == DEMAND) || (state == PREFETCH);
  assign bus.mem_valid = busy;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.bus_err   = bus_err_q;

  // The first cycle of a mem_valid run carries the ROM's stale ready; ignore it.
  always_comb begin
    state_nx = state;
    hit      = bus.cpu_valid && buf_valid && (buf_tag == bus.cpu_addr[31:2]);
    mem_ok   = busy && (cnt != '0) && bus.mem_ready;
    mem_to   = busy && !mem_ok && (cnt == CNT_LAST);
    case (state)
      IDLE: begin
        if (hit)                state_nx = RESP;
        else if (bus.cpu_valid) state_nx = DEMAND;
      end
      DEMAND: begin
        if (mem_ok || mem_to) state_nx = RESP;
      end
      RESP: begin
        if (PREFETCH_EN && req_instr && !req_err) state_nx = PREFETCH;
        else                                      state_nx = IDLE;
      end
      PREFETCH: begin
        if (mem_ok || mem_to) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      req_word    <= '0;
      req_instr   <= 1'b0;
      req_err     <= 1'b0;
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      buf_data    <= '0;
      cnt         <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      bus_err_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state       <= state_nx;
      cpu_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      if (state_nx != state) cnt <= '0;
      else if (busy)         cnt <= cnt + 8'd1;

      case (state)
        IDLE: begin
          if (bus.cpu_valid) begin
            req_word  <= bus.cpu_addr[31:2];
            req_instr <= bus.cpu_instr;
            req_err   <= 1'b0;
            if (hit) begin
              cpu_ready_q <= 1'b1;
              cpu_rdata_q <= buf_data;
            end else begin
              mem_addr_q <= {bus.cpu_addr[31:2], 2'b00};
            end
          end
        end
        DEMAND: begin
          if (mem_ok) begin
            cpu_ready_q <= 1'b1;
            cpu_rdata_q <= bus.mem_rdata;
          end else if (mem_to) begin
            cpu_ready_q <= 1'b1;
            cpu_rdata_q <= ERR_WORD;
            bus_err_q   <= 1'b1;
            req_err     <= 1'b1;
          end
        end
        RESP: begin
          if (state_nx == PREFETCH) mem_addr_q <= {req_word + 30'd1, 2'b00};
        end
        PREFETCH: begin
          if (mem_ok) begin
            buf_valid <= 1'b1;
            buf_tag   <= mem_addr_q[31:2];
            buf_data  <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_progmem_prefetch.sv
// Randomized bench for progmem_prefetch against a transaction-scheduling model.
module tb_progmem_prefetch;

  localparam int          TO   = 16;
  localparam logic [31:0] ERRW = 32'h00100073;
  localparam int          MAXC = 16384;

  logic clk;
  logic rstn;
  progmem_prefetch_if bus ();

  progmem_prefetch #(.TIMEOUT(TO), .PREFETCH_EN(1'b1), .ERR_WORD(ERRW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  int reads8   = 0;
  bit mv_prev  = 1'b0;

  bit          exp_rdy [MAXC];
  bit          exp_err [MAXC];
  logic [31:0] exp_data[MAXC];
  bit          exp_mv  [MAXC];
  logic [31:0] exp_ma  [MAXC];

  bit          m_bvalid;
  logic [29:0] m_btag;
  int          m_free;

  function automatic bit mapped(input logic [29:0] w);
    return (w < 30'd256) || (w == 30'h3FFFFFFF);
  endfunction

  function automatic logic [31:0] rom(input logic [29:0] w);
    case (w)
      30'd0:   return 32'h010205b7;
      30'd1:   return 32'h200107b7;
      30'd2:   return 32'h02040737;
      30'd4:   return 32'h0087a603;
      default: return {w[15:0], ~w[15:0]} ^ 32'h13579bdf;
    endcase
  endfunction

  // ROM: one-cycle registered response; ready is left high (stale) whenever valid was low.
  always @(posedge clk) begin
    if (bus.mem_valid) begin
      bus.mem_ready <= mapped(bus.mem_addr[31:2]);
      bus.mem_rdata <= mapped(bus.mem_addr[31:2]) ? rom(bus.mem_addr[31:2]) : $urandom;
    end else begin
      bus.mem_ready <= 1'b1;
      bus.mem_rdata <= $urandom;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic void set_mv(input int c, input logic [29:0] w);
    if (c < MAXC) begin
      exp_mv[c] = 1'b1;
      exp_ma[c] = {w, 2'b00};
    end
  endfunction

  function automatic void clear_from(input int c);
    for (int k = c; k < MAXC; k++) begin
      exp_rdy[k] = 1'b0; exp_err[k] = 1'b0; exp_data[k] = '0;
      exp_mv[k]  = 1'b0; exp_ma[k]  = '0;
    end
  endfunction

  // Request issued in cycle i: when is it evaluated, how long does it take, what follows.
  function automatic void sched(input int i, input logic [29:0] w, input bit instr);
    int e, r, d;
    bit err;
    logic [29:0] p;
    e = (i > m_free) ? i : m_free;
    err = 1'b0;
    if (m_bvalid && m_btag == w) begin
      r = e + 1;
    end else begin
      d = mapped(w) ? 2 : TO;
      for (int k = 1; k <= d; k++) set_mv(e + k, w);
      r = e + d + 1;
      err = !mapped(w);
    end
    if (r < MAXC) begin
      exp_rdy[r]  = 1'b1;
      exp_err[r]  = err;
      exp_data[r] = err ? ERRW : rom(w);
    end
    if (instr && !err) begin
      p = w + 30'd1;
      d = mapped(p) ? 2 : TO;
      for (int k = 1; k <= d; k++) set_mv(r + k, p);
      if (mapped(p)) begin
        m_bvalid = 1'b1;
        m_btag   = p;
      end
      m_free = r + d + 1;
    end else begin
      m_free = r + 1;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      chk("cpu_ready", {31'd0, bus.cpu_ready}, {31'd0, exp_rdy[cyc]});
      chk("bus_err",   {31'd0, bus.bus_err},   {31'd0, exp_err[cyc]});
      if (exp_rdy[cyc]) chk("cpu_rdata", bus.cpu_rdata, exp_data[cyc]);
      chk("mem_valid", {31'd0, bus.mem_valid}, {31'd0, exp_mv[cyc]});
      if (exp_mv[cyc]) chk("mem_addr", bus.mem_addr, exp_ma[cyc]);
    end
    if (bus.mem_valid && !mv_prev && bus.mem_addr == 32'h8) reads8++;
    mv_prev = bus.mem_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_req(input logic [31:0] a, input bit instr, input int gap,
                        output int lat, output logic [31:0] rd, output logic er);
    int t0;
    bit got;
    repeat (gap) tick();
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_instr = instr;
    t0 = cyc;
    sched(cyc, a[31:2], instr);
    got = 1'b0;
    lat = -1; rd = '0; er = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (bus.cpu_ready === 1'b1) begin
        got = 1'b1;
        lat = cyc - t0;
        rd  = bus.cpu_rdata;
        er  = bus.bus_err;
      end else begin
        tick();
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL req_timeout addr=%h actual=no_ready required=cpu_ready", a);
    end
    tick();
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = $urandom;
    bus.cpu_instr = 1'($urandom);
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic er;
    logic [29:0] w;
    int sel;

    clear_from(0);
    m_bvalid = 1'b0; m_btag = '0; m_free = 0;
    rstn = 1'b0;
    bus.cpu_valid = 1'b0; bus.cpu_instr = 1'b0; bus.cpu_addr = '0;
    repeat (3) tick();
    rstn = 1'b1;
    m_free = cyc;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_bus_err",   {31'd0, bus.bus_err}, 32'd0);
    chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_mem_addr",  bus.mem_addr, 32'd0);
    chk("rst_buf_valid", {31'd0, dut.buf_valid}, 32'd0);
    tick();

    do_req(32'h0, 1'b1, 0, lat, rd, er);
    chk("t1_lat", lat, 32'd3);
    chk("t1_data", rd, 32'h010205b7);
    do_req(32'h4, 1'b1, 3, lat, rd, er);
    chk("t2_lat", lat, 32'd1);
    chk("t2_data", rd, 32'h200107b7);
    do_req(32'h8, 1'b1, 0, lat, rd, er);
    chk("t3_lat", lat, 32'd3);
    chk("t3_data", rd, 32'h02040737);
    chk("t3_reads8", reads8, 32'd1);
    do_req(32'h1000, 1'b1, 3, lat, rd, er);
    chk("t4_lat", lat, 32'd17);
    chk("t4_data", rd, 32'h00100073);
    chk("t4_err", {31'd0, er}, 32'd1);
    do_req(32'h14, 1'b1, 0, lat, rd, er);
    chk("t4_next_lat", lat, 32'd3);
    chk("t4_next_err", {31'd0, er}, 32'd0);
    do_req(32'h10, 1'b0, 3, lat, rd, er);
    chk("t5_lat", lat, 32'd3);
    chk("t5_data", rd, 32'h0087a603);
    do_req(32'h10, 1'b0, 0, lat, rd, er);
    chk("t5_repeat_lat", lat, 32'd3);

    // Abort a demand read with reset; the ROM answers into the reset cycle.
    repeat (2) tick();
    bus.cpu_valid = 1'b1; bus.cpu_addr = 32'h80; bus.cpu_instr = 1'b1;
    sched(cyc, 30'h20, 1'b1);
    tick();
    rstn = 1'b0;
    bus.cpu_valid = 1'b0;
    clear_from(cyc + 1);
    m_bvalid = 1'b0;
    m_free = cyc + 1;
    @(negedge clk);
    chk("t6_mv_before", {31'd0, bus.mem_valid}, 32'd1);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("t6_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
    chk("t6_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("t6_mem_addr",  bus.mem_addr, 32'd0);
    chk("t6_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("t6_buf_valid", {31'd0, dut.buf_valid}, 32'd0);
    do_req(32'h4, 1'b1, 1, lat, rd, er);
    chk("t6_post_lat", lat, 32'd3);
    chk("t6_post_data", rd, 32'h200107b7);

    w = 30'd1;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 50)      w = (w < 30'd255 || w == 30'h3FFFFFFF) ? w + 30'd1 : 30'($urandom_range(0, 255));
      else if (sel < 65) w = w;
      else if (sel < 85) w = 30'($urandom_range(0, 255));
      else if (sel < 93) w = 30'h3FFFFFFF;
      else               w = 30'($urandom_range(1024, 4095));
      do_req({w, 2'($urandom)}, ($urandom_range(0, 3) != 0), $urandom_range(0, 3), lat, rd, er);
    end

    repeat (TO + 4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=still_running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
